// File: rtl/cache_line_fill_pkg.sv
// Shared cache definitions used by the line-fill engine.
//   fill_state_t : refill FSM states
//   tag_width()  : tag bits left after index, word offset and byte offset
package cache_line_fill_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INVAL = 3'd1,
    READ  = 3'd2,
    TAG   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } fill_state_t;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned index_w,
                                            input int unsigned block_w);
    return addr_w - index_w - block_w - 2;
  endfunction

endpackage

// File: rtl/cache_line_fill.sv
// Refill engine for the direct-mapped cache data/tag RAMs.
// On a miss the target line is invalidated, the line is burst-read from main
// memory critical word first, each word is written into the data RAM, and
// finally the tag is written with valid=1.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_fill_req/i_fill_addr      : miss request from the cache controller
//   o_fill_busy/done/error      : fill status (done/error are 1-cycle pulses)
//   o_mem_rd/o_mem_addr, i_mem_ack/err/rdata : memory read handshake
//   o_data_we/addr/wdata        : cache data RAM write port
//   o_tag_we/addr/wdata/valid   : cache tag RAM write port
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = 32,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned INDEX_WIDTH = 5,
  parameter  int unsigned BLOCK_WIDTH = 2,
  localparam int unsigned TAG_WIDTH   = tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_WIDTH)
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_fill_req,
  input  logic [ADDR_WIDTH-1:0]              i_fill_addr,
  output logic                               o_fill_busy,
  output logic                               o_fill_done,
  output logic                               o_fill_error,
  output logic                               o_mem_rd,
  output logic [ADDR_WIDTH-1:0]              o_mem_addr,
  input  logic                               i_mem_ack,
  input  logic                               i_mem_err,
  input  logic [DATA_WIDTH-1:0]              i_mem_rdata,
  output logic                               o_data_we,
  output logic [INDEX_WIDTH+BLOCK_WIDTH-1:0] o_data_addr,
  output logic [DATA_WIDTH-1:0]              o_data_wdata,
  output logic                               o_tag_we,
  output logic [INDEX_WIDTH-1:0]             o_tag_addr,
  output logic [TAG_WIDTH-1:0]               o_tag_wdata,
  output logic                               o_tag_valid
);

  fill_state_t             state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q,   tag_d;
  logic [INDEX_WIDTH-1:0]  idx_q,   idx_d;
  logic [BLOCK_WIDTH-1:0]  off_q,   off_d;
  logic [BLOCK_WIDTH-1:0]  cnt_q,   cnt_d;

  logic beat_ok;
  logic unused_addr_bits;

  // Byte-offset bits of the miss address never matter: reads are word aligned.
  assign unused_addr_bits = ^i_fill_addr[1:0];

  assign beat_ok = (state_q == READ) && i_mem_ack && !i_mem_err;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_fill_req) begin
          state_d = INVAL;
          tag_d   = i_fill_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          idx_d   = i_fill_addr[INDEX_WIDTH+BLOCK_WIDTH+1 -: INDEX_WIDTH];
          off_d   = i_fill_addr[BLOCK_WIDTH+1:2];
          cnt_d   = '0;
        end
      end
      INVAL: state_d = READ;
      READ: begin
        if (i_mem_ack) begin
          if (i_mem_err) begin
            state_d = ERROR;
          end else begin
            // Offset wraps within the line so the critical word comes first.
            off_d = off_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = TAG;
          end
        end
      end
      TAG:     state_d = DONE;
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address/data outputs are forced to zero whenever their enable is low so
  // that reset and IDLE leave every output at 0.
  always_comb begin
    o_fill_busy  = (state_q != IDLE);
    o_fill_done  = (state_q == DONE);
    o_fill_error = (state_q == ERROR);
    o_mem_rd     = (state_q == READ);
    o_mem_addr   = (state_q == READ) ? {tag_q, idx_q, off_q, 2'b00} : '0;
    o_data_we    = beat_ok;
    o_data_addr  = beat_ok ? {idx_q, off_q} : '0;
    o_data_wdata = beat_ok ? i_mem_rdata : '0;
    o_tag_we     = (state_q == INVAL) || (state_q == TAG);
    o_tag_addr   = o_tag_we ? idx_q : '0;
    o_tag_wdata  = o_tag_we ? tag_q : '0;
    o_tag_valid  = (state_q == TAG);
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill (32-bit address/data, 32 lines,
// 4 words per line). A transaction-level model predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
module tb_cache_line_fill;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_fill_req = 1'b0;
  logic [31:0] i_fill_addr = '0;
  logic        i_mem_ack = 1'b0;
  logic        i_mem_err = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_fill_busy, o_fill_done, o_fill_error, o_mem_rd;
  logic [31:0] o_mem_addr;
  logic        o_data_we;
  logic [6:0]  o_data_addr;
  logic [31:0] o_data_wdata;
  logic        o_tag_we;
  logic [4:0]  o_tag_addr;
  logic [22:0] o_tag_wdata;
  logic        o_tag_valid;

  cache_line_fill #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .INDEX_WIDTH(5),
    .BLOCK_WIDTH(2)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_fill_req  (i_fill_req),
    .i_fill_addr (i_fill_addr),
    .o_fill_busy (o_fill_busy),
    .o_fill_done (o_fill_done),
    .o_fill_error(o_fill_error),
    .o_mem_rd    (o_mem_rd),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_err   (i_mem_err),
    .i_mem_rdata (i_mem_rdata),
    .o_data_we   (o_data_we),
    .o_data_addr (o_data_addr),
    .o_data_wdata(o_data_wdata),
    .o_tag_we    (o_tag_we),
    .o_tag_addr  (o_tag_addr),
    .o_tag_wdata (o_tag_wdata),
    .o_tag_valid (o_tag_valid)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: ws wait states before each ack, bus error on beat err_beat.
  int ws = 0, err_beat = -1, beat = 0, wcnt = 0, n_acks = 0;
  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      if (i_reset && o_mem_rd) begin
        if (wcnt == ws) begin
          i_mem_ack   = 1'b1;
          i_mem_err   = (beat == err_beat);
          i_mem_rdata = o_mem_addr ^ 32'hC0DE_5A00 ^ 32'(beat);
          beat++;
          n_acks++;
          wcnt = 0;
        end else begin
          i_mem_ack   = 1'b0;
          i_mem_err   = 1'b0;
          i_mem_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        i_mem_ack   = 1'b0;
        i_mem_err   = 1'b0;
        i_mem_rdata = 32'hDEAD_BEEF;
        wcnt        = 0;
      end
    end
  end

  // Transaction model: m_t counts cycles since acceptance, m_words counts
  // accepted beats, m_end counts cycles since the last beat or the bus error.
  bit          m_active = 1'b0;
  bit          m_errd = 1'b0;
  int          m_t = 0, m_words = 0, m_end = 0;
  logic [31:0] m_addr = '0;
  int          acc_cyc = 0, done_cyc = 0;
  int          n_accepts = 0, n_writes = 0, n_err_pulses = 0, n_valid_tag = 0;
  logic [22:0] last_vtag = '0;
  logic [4:0]  last_vtag_idx = '0;
  logic [31:0] log_maddr[$];
  logic [6:0]  log_daddr[$];

  always @(negedge i_clock) begin : model_chk
    logic [105:0] e, a;
    logic         rd, inval, tagging, done, errp, dwe, twe;
    logic [1:0]   off;
    logic [31:0]  maddr;
    a = {o_fill_busy, o_fill_done, o_fill_error, o_mem_rd, o_mem_addr,
         o_data_we, o_data_addr, o_data_wdata,
         o_tag_we, o_tag_addr, o_tag_wdata, o_tag_valid};
    if (!i_reset) begin
      e        = '0;
      m_active = 1'b0;
    end else begin
      off     = 2'(int'(m_addr[3:2]) + m_words);
      rd      = m_active && m_t >= 2 && m_end == 0;
      inval   = m_active && m_t == 1;
      tagging = m_active && m_end == 1 && !m_errd;
      done    = m_active && m_end == 2 && !m_errd;
      errp    = m_active && m_end == 1 && m_errd;
      dwe     = rd && i_mem_ack && !i_mem_err;
      twe     = inval || tagging;
      maddr   = rd ? {m_addr[31:4], off, 2'b00} : 32'd0;
      e = {m_active, done, errp, rd, maddr,
           dwe, dwe ? {m_addr[8:4], off} : 7'd0, dwe ? i_mem_rdata : 32'd0,
           twe, twe ? m_addr[8:4] : 5'd0, twe ? m_addr[31:9] : 23'd0, tagging};
      if (dwe) begin
        n_writes++;
        log_maddr.push_back(maddr);
        log_daddr.push_back({m_addr[8:4], off});
      end
      if (done) done_cyc = cyc;
      if (errp) n_err_pulses++;
      if (tagging) begin
        n_valid_tag++;
        last_vtag     = m_addr[31:9];
        last_vtag_idx = m_addr[8:4];
      end
      // Advance to what the coming clock edge must produce.
      if (m_active) begin
        if (m_end > 0) begin
          m_end++;
          if ((m_errd && m_end == 2) || (!m_errd && m_end == 3)) m_active = 1'b0;
        end else if (rd && i_mem_ack) begin
          if (i_mem_err) begin
            m_errd = 1'b1;
            m_end  = 1;
          end else begin
            m_words++;
            if (m_words == 4) m_end = 1;
          end
        end
        m_t++;
      end else if (i_fill_req) begin
        m_active = 1'b1;
        m_errd   = 1'b0;
        m_t      = 1;
        m_words  = 0;
        m_end    = 0;
        m_addr   = i_fill_addr;
        acc_cyc  = cyc;
        n_accepts++;
      end
    end
    check("outputs", 128'(a), 128'(e));
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic start_fill(input logic [31:0] addr, input int w, input int eb);
    ws = w;
    err_beat = eb;
    beat = 0;
    n_acks = 0;
    n_accepts = 0;
    n_writes = 0;
    n_err_pulses = 0;
    n_valid_tag = 0;
    log_maddr.delete();
    log_daddr.delete();
    i_fill_req  = 1'b1;
    i_fill_addr = addr;
    tick();
    i_fill_req  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (m_active && k < 400) begin
      tick();
      k++;
    end
    if (m_active) check({name, " timeout"}, 128'(m_active), 128'(0));
  endtask

  initial begin
    logic [31:0] exp_wrap[4];
    logic [6:0]  exp_daddr[4];
    logic [31:0] exp_seq[4];
    exp_wrap  = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
    exp_daddr = '{7'd13, 7'd14, 7'd15, 7'd12};
    exp_seq   = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};

    tick();
    tick();
    i_reset = 1'b1;
    tick();

    // 1) critical-word-first wrap, zero wait states
    start_fill(32'h0000_1234, 0, -1);
    wait_idle("t1");
    check("t1 done cycle", 128'(done_cyc - acc_cyc), 128'(7));
    check("t1 beats", 128'(log_maddr.size()), 128'(4));
    for (int i = 0; i < 4 && i < log_maddr.size(); i++) begin
      check("t1 mem addr", 128'(log_maddr[i]), 128'(exp_wrap[i]));
      check("t1 data addr", 128'(log_daddr[i]), 128'(exp_daddr[i]));
    end
    check("t1 valid tag writes", 128'(n_valid_tag), 128'(1));
    tick();

    // 2) three wait states per word
    start_fill(32'h0000_1234, 3, -1);
    wait_idle("t2");
    check("t2 done cycle", 128'(done_cyc - acc_cyc), 128'(19));
    check("t2 beats", 128'(n_writes), 128'(4));
    check("t2 acks", 128'(n_acks), 128'(4));
    tick();

    // 3) bus error on the third word
    start_fill(32'h0000_1234, 0, 2);
    wait_idle("t3");
    check("t3 data writes", 128'(n_writes), 128'(2));
    check("t3 error pulses", 128'(n_err_pulses), 128'(1));
    check("t3 valid tag writes", 128'(n_valid_tag), 128'(0));
    tick();

    // 4) requests during READ and in the DONE cycle are dropped
    start_fill(32'h0000_1234, 0, -1);   // now in cycle 1
    tick();                              // cycle 2, READ
    i_fill_req  = 1'b1;
    i_fill_addr = 32'h0000_5670;
    tick();                              // cycle 3
    i_fill_req  = 1'b0;
    tick();
    tick();
    tick();                              // cycle 6, TAG
    tick();                              // cycle 7, DONE
    i_fill_req  = 1'b1;
    tick();                              // cycle 8
    i_fill_req  = 1'b0;
    wait_idle("t4a");
    check("t4 accepts", 128'(n_accepts), 128'(1));
    check("t4 acks", 128'(n_acks), 128'(4));
    tick();
    tick();
    start_fill(32'h0000_5670, 0, -1);
    wait_idle("t4b");
    check("t4 next accepts", 128'(n_accepts), 128'(1));
    check("t4 next done cycle", 128'(done_cyc - acc_cyc), 128'(7));
    tick();

    // 5) reset in the second READ cycle, then a clean fill
    start_fill(32'h0000_1234, 0, -1);   // cycle 1
    tick();                              // cycle 2, first READ
    tick();                              // cycle 3, second READ
    i_reset = 1'b0;
    #1;
    check("t5 async reset", 128'({o_fill_busy, o_mem_rd, o_data_we, o_tag_we,
                                 o_fill_done, o_fill_error, o_mem_addr}), 128'(0));
    tick();
    i_reset = 1'b1;
    tick();
    start_fill(32'h0000_2A38, 1, -1);
    wait_idle("t5");
    check("t5 refill beats", 128'(n_writes), 128'(4));
    check("t5 refill valid tag", 128'(n_valid_tag), 128'(1));
    tick();

    // 6) offset 0: sequential reads, tag = addr[31:9]
    start_fill(32'h0000_1230, 0, -1);
    wait_idle("t6");
    check("t6 beats", 128'(log_maddr.size()), 128'(4));
    for (int i = 0; i < 4 && i < log_maddr.size(); i++)
      check("t6 mem addr", 128'(log_maddr[i]), 128'(exp_seq[i]));
    check("t6 tag", 128'(last_vtag), 128'(23'h9));
    check("t6 tag index", 128'(last_vtag_idx), 128'(5'd3));
    check("t6 done cycle", 128'(done_cyc - acc_cyc), 128'(7));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
